// File: rtl/dtc_share_arbiter.sv
// dtc_share_arbiter: round-robin sharing of one combinational decision-tree
// classifier between NREQ feature producers. The winning feature vector is
// registered onto cls_inp, held for EVAL_CYC cycles, and the classifier
// output is captured and returned tagged with the owner's index.
//
// Optional feature macro: DTC_ARB_STATS_EN builds per-requester saturating
// 16-bit completed-result counters on stat_cnt; otherwise stat_cnt is 0.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid and ready are both high. A valid source holds its payload
// stable until that edge; ready may depend combinationally on valid.
module dtc_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int EVAL_CYC = 1,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*8-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           cls_inp,
    input  logic [7:0]           cls_outp,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [7:0]           res_data,
    output logic [IDW-1:0]       res_id,
    output logic [NREQ*16-1:0]   stat_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [3:0]       cnt_q;
    logic [7:0]       cls_inp_q;
    logic             res_valid_q;
    logic [7:0]       res_data_q;
    logic [IDW-1:0]   res_id_q;

    logic             found;
    logic [IDW-1:0]   grant_idx_d;
    logic [IDW-1:0]   scan_idx;
    logic             accept;
    logic             res_hs;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        found       = 1'b0;
        grant_idx_d = '0;
        scan_idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && req_valid[scan_idx]) begin
                found       = 1'b1;
                grant_idx_d = scan_idx;
            end
        end
    end

    // One-hot grant, only offered while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found) begin
            req_ready[grant_idx_d] = 1'b1;
        end
    end

    assign accept = (state_q == IDLE) && found;
    assign res_hs = res_valid_q && res_ready;

    // Transaction FSM: accept, hold classifier input while it settles, present result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            cls_inp_q   <= 8'h00;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cls_inp_q <= req_data[{grant_idx_d, 3'b000} +: 8];
                        id_q      <= grant_idx_d;
                        rr_ptr_q  <= grant_idx_d;
                        cnt_q     <= 4'(EVAL_CYC - 1);
                        state_q   <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        res_data_q  <= cls_outp;
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cls_inp   = cls_inp_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

`ifdef DTC_ARB_STATS_EN
    logic [NREQ*16-1:0] stat_q;

    // Count completed result handshakes per owner, saturating at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (res_hs && stat_q[{res_id_q, 4'b0000} +: 16] != 16'hFFFF) begin
            stat_q[{res_id_q, 4'b0000} +: 16] <= stat_q[{res_id_q, 4'b0000} +: 16] + 16'd1;
        end
    end

    assign stat_cnt = stat_q;
`else
    logic unused_hs;
    assign unused_hs = res_hs;
    assign stat_cnt  = '0;
`endif

endmodule

// File: tb/tb_dtc_share_arbiter.sv
// Directed bench for dtc_share_arbiter: classifier model is ~cls_inp for the
// EVAL_CYC=1 instance, and a slow-settling model for an EVAL_CYC=4 instance.
module tb_dtc_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    // EVAL_CYC = 1 instance
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  cls_inp;
    logic [7:0]  cls_outp;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic [63:0] stat_cnt;

    // EVAL_CYC = 4 instance
    logic [3:0]  req_valid4 = '0;
    logic [31:0] req_data4 = '0;
    logic [3:0]  req_ready4;
    logic [7:0]  cls_inp4;
    logic [7:0]  cls_outp4;
    logic        res_valid4;
    logic        res_ready4 = 1'b0;
    logic [7:0]  res_data4;
    logic [1:0]  res_id4;
    logic [63:0] stat_cnt4;
    logic [7:0]  prev4 = 8'h00;
    logic [3:0]  age4 = 4'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cls_outp = ~cls_inp;

    // Slow classifier: output is garbage until the input has been stable
    // through three rising edges after it changed.
    always @(posedge clk) begin
        if (cls_inp4 !== prev4) age4 <= 4'd0;
        else if (age4 != 4'hF) age4 <= age4 + 4'd1;
        prev4 <= cls_inp4;
    end
    assign cls_outp4 = (cls_inp4 === prev4 && age4 >= 4'd2) ? ~cls_inp4 : 8'hEE;

    dtc_share_arbiter #(.NREQ(4), .EVAL_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cls_inp(cls_inp), .cls_outp(cls_outp),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .stat_cnt(stat_cnt)
    );

    dtc_share_arbiter #(.NREQ(4), .EVAL_CYC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid4), .req_data(req_data4), .req_ready(req_ready4),
        .cls_inp(cls_inp4), .cls_outp(cls_outp4),
        .res_valid(res_valid4), .res_ready(res_ready4),
        .res_data(res_data4), .res_id(res_id4), .stat_cnt(stat_cnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        req_valid4 = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_miss++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        n_vec++; if (cls_inp !== 8'h00) begin n_miss++; $display("FAIL rst_cls_inp: got %h want 00", cls_inp); end
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        n_vec++; if (res_data !== 8'h00) begin n_miss++; $display("FAIL rst_res_data: got %h want 00", res_data); end
        n_vec++; if (res_id !== 2'd0) begin n_miss++; $display("FAIL rst_res_id: got %0d want 0", res_id); end
        n_vec++; if (stat_cnt !== 64'd0) begin n_miss++; $display("FAIL rst_stat_cnt: got %h want 0", stat_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL rst_first_prio: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        res_ready = 1'b1;
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        n_vec++; if (req_ready !== 4'b0000) begin n_miss++; $display("FAIL single_ready_eval: got %b want 0000", req_ready); end
        n_vec++; if (cls_inp !== 8'h5A) begin n_miss++; $display("FAIL single_cls_inp: got %h want 5a", cls_inp); end
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL single_valid_early: got %b want 0", res_valid); end
        step();
        n_vec++; if (res_valid !== 1'b1) begin n_miss++; $display("FAIL single_valid: got %b want 1", res_valid); end
        n_vec++; if (res_data !== 8'hA5) begin n_miss++; $display("FAIL single_data: got %h want a5", res_data); end
        n_vec++; if (res_id !== 2'd0) begin n_miss++; $display("FAIL single_id: got %0d want 0", res_id); end
        step();
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL single_valid_drop: got %b want 0", res_valid); end
        n_vec++; if (cls_inp !== 8'h5A) begin n_miss++; $display("FAIL single_cls_retain: got %h want 5a", cls_inp); end
    endtask

    task automatic test_round_robin();
        int g_exp [5] = '{0, 1, 2, 3, 0};
        int ng = 0;
        int nr = 0;
        int last = 0;
        logic [3:0] oh;
        logic [7:0] d_exp;
        do_reset();
        res_ready = 1'b1;
        req_data = {8'h30, 8'h20, 8'h10, 8'h00};
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (req_ready !== 4'b0000 && ng < 5) begin
                oh = 4'b0001 << g_exp[ng];
                n_vec++; if (req_ready !== oh) begin n_miss++; $display("FAIL rr_grant%0d: got %b want %b", ng, req_ready, oh); end
                if (ng > 0) begin
                    n_vec++; if (cyc - last !== 3) begin n_miss++; $display("FAIL rr_period%0d: got %0d want 3", ng, cyc - last); end
                end
                last = cyc;
                ng++;
            end
            if (res_valid === 1'b1 && nr < 5) begin
                d_exp = ~(8'(g_exp[nr]) << 4);
                n_vec++; if (res_data !== d_exp) begin n_miss++; $display("FAIL rr_data%0d: got %h want %h", nr, res_data, d_exp); end
                n_vec++; if (res_id !== 2'(g_exp[nr])) begin n_miss++; $display("FAIL rr_id%0d: got %0d want %0d", nr, res_id, g_exp[nr]); end
                nr++;
            end
            step();
        end
        req_valid = '0;
        n_vec++; if (ng !== 5) begin n_miss++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
        n_vec++; if (nr !== 5) begin n_miss++; $display("FAIL rr_result_count: got %0d want 5", nr); end
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        do_reset();
        res_ready = 1'b0;
        req_data[23:16] = 8'h33;
        req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_miss++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        step();
        req_data[7:0] = 8'h77;
        req_valid = 4'b0001;
        step();
        for (int k = 0; k < 10; k++) begin
            n_vec++; if (res_valid !== 1'b1) begin n_miss++; $display("FAIL bp_valid%0d: got %b want 1", k, res_valid); end
            n_vec++; if (res_data !== 8'hCC) begin n_miss++; $display("FAIL bp_data%0d: got %h want cc", k, res_data); end
            n_vec++; if (res_id !== 2'd2) begin n_miss++; $display("FAIL bp_id%0d: got %0d want 2", k, res_id); end
            n_vec++; if (req_ready !== 4'b0000) begin n_miss++; $display("FAIL bp_ready%0d: got %b want 0000", k, req_ready); end
            step();
        end
        res_ready = 1'b1;
        step();
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL bp_release: got %b want 0", res_valid); end
        n_vec++; if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        step();
        n_vec++; if (res_data !== 8'h88) begin n_miss++; $display("FAIL bp_next_data: got %h want 88", res_data); end
        n_vec++; if (res_id !== 2'd0) begin n_miss++; $display("FAIL bp_next_id: got %0d want 0", res_id); end
        step();
    endtask

    task automatic test_eval_cyc4();
        do_reset();
        res_ready4 = 1'b1;
        req_data4[7:0] = 8'h3C;
        req_valid4 = 4'b0001;
        #1;
        n_vec++; if (req_ready4 !== 4'b0001) begin n_miss++; $display("FAIL ev4_grant: got %b want 0001", req_ready4); end
        step();
        req_valid4 = '0;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_vec++; if (res_valid4 !== 1'b0) begin n_miss++; $display("FAIL ev4_early%0d: got %b want 0", k, res_valid4); end
            n_vec++; if (cls_inp4 !== 8'h3C) begin n_miss++; $display("FAIL ev4_hold%0d: got %h want 3c", k, cls_inp4); end
        end
        step();
        n_vec++; if (res_valid4 !== 1'b1) begin n_miss++; $display("FAIL ev4_valid: got %b want 1", res_valid4); end
        n_vec++; if (res_data4 !== 8'hC3) begin n_miss++; $display("FAIL ev4_data: got %h want c3", res_data4); end
        n_vec++; if (res_id4 !== 2'd0) begin n_miss++; $display("FAIL ev4_id: got %0d want 0", res_id4); end
        step();
        n_vec++; if (res_valid4 !== 1'b0) begin n_miss++; $display("FAIL ev4_drop: got %b want 0", res_valid4); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b1;
        req_data[7:0] = 8'h44;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        n_vec++; if (cls_inp !== 8'h44) begin n_miss++; $display("FAIL rmid_cls_before: got %h want 44", cls_inp); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL rmid_valid: got %b want 0", res_valid); end
        n_vec++; if (cls_inp !== 8'h00) begin n_miss++; $display("FAIL rmid_cls: got %h want 00", cls_inp); end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL rmid_no_result%0d: got %b want 0", k, res_valid); end
        end
        req_data[15:8] = 8'h55;
        req_valid = 4'b0011;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL rmid_next_grant: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        step();
        n_vec++; if (res_data !== 8'hBB) begin n_miss++; $display("FAIL rmid_data: got %h want bb", res_data); end
        step();
    endtask

    task automatic test_stats();
        logic [15:0] exp1;
        int w;
`ifdef DTC_ARB_STATS_EN
        exp1 = 16'd5;
`else
        exp1 = 16'd0;
`endif
        do_reset();
        res_ready = 1'b1;
        req_data[15:8] = 8'h21;
        for (int n = 0; n < 5; n++) begin
            req_valid = 4'b0010;
            #1;
            w = 0;
            while (req_ready[1] !== 1'b1 && w < 8) begin
                step();
                w++;
            end
            n_vec++; if (w >= 8) begin n_miss++; $display("FAIL stat_wait%0d: got no grant want grant within 8 cycles", n); end
            step();
            req_valid = '0;
            step();
            step();
        end
        n_vec++; if (stat_cnt[31:16] !== exp1) begin n_miss++; $display("FAIL stat_req1: got %0d want %0d", stat_cnt[31:16], exp1); end
        n_vec++; if (stat_cnt[15:0] !== 16'd0) begin n_miss++; $display("FAIL stat_req0: got %0d want 0", stat_cnt[15:0]); end
        n_vec++; if (stat_cnt[63:32] !== 32'd0) begin n_miss++; $display("FAIL stat_req23: got %h want 0", stat_cnt[63:32]); end
        do_reset();
        #1;
        n_vec++; if (stat_cnt !== 64'd0) begin n_miss++; $display("FAIL stat_clear: got %h want 0", stat_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_eval_cyc4();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/dtc_share_arbiter.md
# dtc_share_arbiter

Shares one combinational decision-tree classifier (8-bit feature vector in, 8-bit class word out) between NREQ requesters. It arbitrates round-robin, registers the winning feature vector onto the classifier input, and waits a programmable settle time. It then captures the classifier output and returns it to the requester tagged with that requester's index. It sits between feature producers and a single `dtc_*` classifier instance, so the classifier is never duplicated per source.

## Interface
Parameters:
- NREQ, 4: number of requesters; legal range 2..16.
- EVAL_CYC, 1: cycles the classifier input is held before the output is captured; legal range 1..15.
- IDW, $clog2(NREQ) (localparam): width of the requester index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*8  feature vectors; requester i uses bits [8i+7:8i].
- req_ready  out  NREQ  one-hot grant/accept; a transfer occurs on req_valid[i] & req_ready[i].
- cls_inp  out  8  registered feature vector driven to the classifier.
- cls_outp  in  8  classifier result (combinational function of cls_inp).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  captured classifier result.
- res_id  out  IDW  index of the requester that owns res_data.
- stat_cnt  out  NREQ*16  per-requester completed-result counters (see Configuration).

## Operation
- FSM states: IDLE, EVAL, HOLD. Reset state: IDLE.
- IDLE:
  - Search req_valid starting at index (rr_ptr+1) mod NREQ, wrapping.
  - The first set bit g wins. req_ready is one-hot at g, combinational from req_valid and rr_ptr.
  - No valid request: req_ready = 0 and the block stays in IDLE.
  - On transfer: cls_inp <= req_data[g], id register <= g, rr_ptr <= g, eval counter <= EVAL_CYC-1, state <= EVAL.
- EVAL:
  - cls_inp is held constant.
  - Counter nonzero: decrement.
  - Counter zero: res_data <= cls_outp, res_id <= id register, res_valid <= 1, state <= HOLD.
- HOLD:
  - res_valid = 1. res_data and res_id are stable until handshake.
  - On res_valid & res_ready: res_valid <= 0, state <= IDLE.
- req_ready is 0 in EVAL and HOLD.
- Requesters must hold req_valid and req_data stable until accepted. A requester that drops req_valid before being accepted is simply not served.
- cls_inp retains the last accepted vector after the transaction completes.
- Simultaneous requests are resolved strictly by the round-robin order. A requester is never granted twice while another valid requester is waiting.

## Timing
- Reset values: req_ready = 0, cls_inp = 0x00, res_valid = 0, res_data = 0x00, res_id = 0, stat_cnt = 0, rr_ptr = NREQ-1 (so requester 0 has priority after reset).
- Accept at edge T: res_valid is high from edge T+EVAL_CYC.
- The classifier output is sampled at edge T+EVAL_CYC, after cls_inp has been stable for EVAL_CYC cycles.
- If res_ready is already high when res_valid rises, the handshake completes at the next edge. The following grant can be accepted one edge later.
- Minimum request-to-request period: EVAL_CYC+2 cycles.
- Back-pressure: res_ready held low keeps the block in HOLD indefinitely. No request is accepted during that time.
- Reset asserted mid-transaction: all registers clear asynchronously and the in-flight transaction is dropped with no result. After reset deassertion, operation restarts in IDLE with requester 0 first.

## Configuration
- DTC_ARB_STATS_EN defined:
  - stat_cnt[16i+15:16i] increments on each result handshake where res_id = i.
  - Counters saturate at 0xFFFF and clear only on reset.
- DTC_ARB_STATS_EN undefined:
  - Counters are not built and stat_cnt is tied to 0.
  - All other behaviour is identical.

## Test plan
- Bench classifier model: cls_outp = ~cls_inp. Parameters: NREQ=4, EVAL_CYC=1.
- Single request: req_valid=0001, data0=0x5A, res_ready=1 -> req_ready=0001 for one cycle; res_valid one edge after accept; res_data=0xA5, res_id=0.
- All four requesting continuously, data i = 0x10*i -> grant order 0,1,2,3,0; results 0xFF, 0xEF, 0xDF, 0xCF; accept-to-accept period 3 cycles.
- res_ready held low for 10 cycles while requester 2 (data 0x33) is pending -> res_valid held with res_data=0xCC and res_id=2 throughout; req_ready=0 throughout; completes on the first cycle res_ready=1.
- EVAL_CYC=4 with the bench model changing cls_outp only after 3 cycles -> captured value reflects the settled output, sampled exactly 4 edges after accept.
- rst_n pulsed low while in EVAL -> res_valid stays 0, cls_inp=0x00, no result emitted; next grant goes to requester 0.
- With DTC_ARB_STATS_EN defined, 5 results for requester 1 -> stat_cnt[31:16]=5. Without the macro, stat_cnt=0.
